// File: rtl/accel_pkg.sv
// Shared accelerator definitions: SRAM instruction codes, job state encoding
// and default image geometry used by every accelerator job.
package accel_pkg;

    localparam logic [7:0] INST_NOP   = 8'd0;
    localparam logic [7:0] INST_WRITE = 8'd2;
    localparam logic [7:0] INST_READ  = 8'd3;

    localparam int IMG_WIDTH_DEF  = 128;
    localparam int IMG_HEIGHT_DEF = 128;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_STREAM = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

endpackage

// File: rtl/mask_statistics_pkg.sv
// mask_statistics local definitions: flat state constants (legacy encoding) and
// centroid accumulator width used when MASK_STATISTICS_CENTROID_EN is defined.
package mask_statistics_pkg;

    import accel_pkg::*;

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_SETUP  = ST_SETUP;
    localparam logic [2:0] S_ISSUE  = ST_ISSUE;
    localparam logic [2:0] S_STREAM = ST_STREAM;
    localparam logic [2:0] S_FINISH = ST_FINISH;

    // Holds 128 * sum(0..127) with one bit of headroom.
    localparam int SUM_W = 21;

endpackage

// File: rtl/mask_statistics_if.sv
// Four-SRAM instruction/address/byte_length bundle with the bit-serial read path.
interface mask_statistics_if;

    // An SRAM sends one mask bit on mem_out[i] in every cycle io_valid[i] is high;
    // rw_done[i] is a single-cycle pulse ending its transfer and may coincide
    // with the last valid bit. There is no back-pressure on the stream.
    logic [7:0]  inst        [0:3];
    logic [23:0] address     [0:3];
    logic [23:0] byte_length [0:3];
    logic [3:0]  mem_out;
    logic [3:0]  io_valid;
    logic [3:0]  rw_done;

    modport master (
        output inst, address, byte_length,
        input  mem_out, io_valid, rw_done
    );

    modport slave (
        input  inst, address, byte_length,
        output mem_out, io_valid, rw_done
    );

endinterface

// File: rtl/pixel_position_counter.sv
// Raster position tracker for the mask stream: x wraps at the row width, then y
// advances; stops at a full image so overrun bits cannot wrap the counters.
module pixel_position_counter #(
    parameter  int IMG_WIDTH  = 128,
    parameter  int IMG_HEIGHT = 128,
    localparam int X_W        = $clog2(IMG_WIDTH),
    localparam int Y_W        = $clog2(IMG_HEIGHT),
    localparam int IMG_LENGTH = IMG_WIDTH * IMG_HEIGHT,
    localparam int CNT_W      = $clog2(IMG_LENGTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [CNT_W-1:0] bit_count,
    output logic             full
);

    assign full = (bit_count == CNT_W'(IMG_LENGTH));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            x         <= '0;
            y         <= '0;
            bit_count <= '0;
        end else if (advance && !full) begin
            bit_count <= bit_count + 1'b1;
            if (x == X_W'(IMG_WIDTH - 1)) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mask_statistics.sv
// Foreground-mask statistics job: reads the mask from one SRAM and reports pixel
// count and bounding box. Defining MASK_STATISTICS_CENTROID_EN adds sum_x/sum_y.
module mask_statistics
    import accel_pkg::*;
    import mask_statistics_pkg::*;
#(
    parameter  int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter  int IMG_HEIGHT = IMG_HEIGHT_DEF,
    localparam int X_W        = $clog2(IMG_WIDTH),
    localparam int Y_W        = $clog2(IMG_HEIGHT),
    localparam int IMG_LENGTH = IMG_WIDTH * IMG_HEIGHT,
    localparam int CNT_W      = $clog2(IMG_LENGTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           sram_select_in,
    input  logic [23:0]          inst_address,
    mask_statistics_if.master    sram,
    input  logic                 execute,
    output logic                 job_done,
    output logic [CNT_W-1:0]     fg_count,
    output logic [X_W-1:0]       min_x,
    output logic [X_W-1:0]       max_x,
    output logic [Y_W-1:0]       min_y,
    output logic [Y_W-1:0]       max_y,
    output logic                 bbox_valid,
    output logic                 short_read,
`ifdef MASK_STATISTICS_CENTROID_EN
    output logic [SUM_W-1:0]     sum_x,
    output logic [SUM_W-1:0]     sum_y,
`endif
    output logic [2:0]           dbg_state
);

    logic [2:0]       state;
    logic [1:0]       sel;
    logic [X_W-1:0]   min_x_q, max_x_q, cur_x;
    logic [Y_W-1:0]   min_y_q, max_y_q, cur_y;
    logic [CNT_W-1:0] bit_count;
    logic             full;
    logic             pos_clear;
    logic             bit_take;
    logic             bit_fg;
    logic [CNT_W:0]   bits_seen;

    assign pos_clear = (state == S_IDLE) && execute;
    assign bit_take  = (state == S_STREAM) && sram.io_valid[sel] && !full;
    assign bit_fg    = bit_take && sram.mem_out[sel];
    // Bits received including one arriving alongside rw_done.
    assign bits_seen = {1'b0, bit_count} + (CNT_W+1)'(bit_take);

    pixel_position_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (pos_clear),
        .advance   (bit_take),
        .x         (cur_x),
        .y         (cur_y),
        .bit_count (bit_count),
        .full      (full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sel        <= '0;
            job_done   <= 1'b0;
            fg_count   <= '0;
            bbox_valid <= 1'b0;
            short_read <= 1'b0;
            min_x_q    <= '0;
            max_x_q    <= '0;
            min_y_q    <= '0;
            max_y_q    <= '0;
`ifdef MASK_STATISTICS_CENTROID_EN
            sum_x      <= '0;
            sum_y      <= '0;
`endif
            for (int i = 0; i < 4; i++) begin
                sram.inst[i]        <= INST_NOP;
                sram.address[i]     <= '0;
                sram.byte_length[i] <= '0;
            end
        end else begin
            job_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (execute) begin
                        sel        <= sram_select_in;
                        fg_count   <= '0;
                        bbox_valid <= 1'b0;
                        short_read <= 1'b0;
                        min_x_q    <= '1;
                        min_y_q    <= '1;
                        max_x_q    <= '0;
                        max_y_q    <= '0;
`ifdef MASK_STATISTICS_CENTROID_EN
                        sum_x      <= '0;
                        sum_y      <= '0;
`endif
                        sram.address[sram_select_in]     <= inst_address;
                        sram.byte_length[sram_select_in] <= 24'(IMG_LENGTH / 8);
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    sram.inst[sel] <= INST_READ;
                    state          <= S_ISSUE;
                end
                S_ISSUE: begin
                    sram.inst[sel] <= INST_NOP;
                    state          <= S_STREAM;
                end
                S_STREAM: begin
                    if (bit_fg) begin
                        fg_count   <= fg_count + 1'b1;
                        bbox_valid <= 1'b1;
                        if (cur_x < min_x_q) min_x_q <= cur_x;
                        if (cur_x > max_x_q) max_x_q <= cur_x;
                        if (cur_y < min_y_q) min_y_q <= cur_y;
                        if (cur_y > max_y_q) max_y_q <= cur_y;
`ifdef MASK_STATISTICS_CENTROID_EN
                        sum_x <= sum_x + SUM_W'(cur_x);
                        sum_y <= sum_y + SUM_W'(cur_y);
`endif
                    end
                    if (sram.rw_done[sel]) begin
                        short_read <= (bits_seen < (CNT_W+1)'(IMG_LENGTH));
                        job_done   <= 1'b1;
                        state      <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    for (int i = 0; i < 4; i++) begin
                        sram.address[i]     <= '0;
                        sram.byte_length[i] <= '0;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The min registers start at all-ones, so hide them until a pixel is seen.
    assign min_x     = bbox_valid ? min_x_q : '0;
    assign max_x     = bbox_valid ? max_x_q : '0;
    assign min_y     = bbox_valid ? min_y_q : '0;
    assign max_y     = bbox_valid ? max_y_q : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_mask_statistics.sv
// Directed-vector bench for mask_statistics; each record describes one READ job
// (pattern, SRAM, stream shape) with hand-computed statistics.
`timescale 1ns/1ps
module tb_mask_statistics;
    import accel_pkg::*;
    import mask_statistics_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  sram_select_in;
    logic [23:0] inst_address;
    logic        execute;
    logic        job_done;
    logic [14:0] fg_count;
    logic [6:0]  min_x, max_x, min_y, max_y;
    logic        bbox_valid, short_read;
    logic [2:0]  dbg_state;
`ifdef MASK_STATISTICS_CENTROID_EN
    logic [20:0] sum_x, sum_y;
`endif

    mask_statistics_if sram();

    mask_statistics dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sram_select_in (sram_select_in),
        .inst_address   (inst_address),
        .sram           (sram.master),
        .execute        (execute),
        .job_done       (job_done),
        .fg_count       (fg_count),
        .min_x          (min_x),
        .max_x          (max_x),
        .min_y          (min_y),
        .max_y          (max_y),
        .bbox_valid     (bbox_valid),
        .short_read     (short_read),
`ifdef MASK_STATISTICS_CENTROID_EN
        .sum_x          (sum_x),
        .sum_y          (sum_y),
`endif
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int fails  = 0;
    int jd_count = 0;
    int read_cycles = 0;

    always @(posedge clk) begin
        #2;
        if (job_done) jd_count++;
        for (int i = 0; i < 4; i++)
            if (sram.inst[i] == INST_READ) read_cycles++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int         pat;
        logic [1:0] sel;
        int         nbits;
        bit         same_cycle;
        bit         gappy;
        bit         glitch;
        bit         reexec;
        int         e_count;
        int         e_minx, e_maxx, e_miny, e_maxy;
        bit         e_valid;
        bit         e_short;
        int         e_sumx, e_sumy;
    } vec_t;

    vec_t vecs[6];

    function automatic logic mask_bit(input int pat, input int k);
        int x, y;
        x = k % 128;
        y = k / 128;
        case (pat)
            1:       return (k == 130);
            2:       return (x >= 10 && x <= 20 && y >= 5 && y <= 9);
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle_inputs();
        sram.io_valid = '0;
        sram.mem_out  = '0;
        sram.rw_done  = '0;
        execute       = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic run_job(input vec_t v, input int abort_at);
        logic [23:0] addr;
        addr = 24'h100 * (v.sel + 1) + 24'h5;
        jd_count = 0;
        read_cycles = 0;
        @(negedge clk);
        execute = 1'b1;
        sram_select_in = v.sel;
        inst_address = addr;
        @(negedge clk);
        execute = 1'b0;
        sram_select_in = ~v.sel;
        inst_address = '0;
        check("setup_state", dbg_state, S_SETUP);
        check("setup_addr", sram.address[v.sel], addr);
        check("setup_len", sram.byte_length[v.sel], 2048);
        check("setup_inst", sram.inst[v.sel], INST_NOP);
        @(negedge clk);
        check("issue_inst", sram.inst[v.sel], INST_READ);
        @(negedge clk);
        check("stream_inst", sram.inst[v.sel], INST_NOP);
        check("stream_addr_held", sram.address[v.sel], addr);

        for (int k = 0; k < v.nbits; k++) begin
            if (v.gappy && (k % 2 == 1)) begin
                sram.io_valid = v.glitch ? 4'hF : 4'h0;
                sram.io_valid[v.sel] = 1'b0;
                sram.mem_out = 4'hF;
                sram.rw_done = '0;
                execute = 1'b0;
                @(negedge clk);
            end
            if (k == abort_at) begin
                rst_n = 1'b0;
                idle_inputs();
                @(negedge clk);
                check("abort_state", dbg_state, S_IDLE);
                check("abort_count", fg_count, 0);
                check("abort_bbox", {bbox_valid, short_read, job_done}, 0);
                for (int i = 0; i < 4; i++)
                    check("abort_port", {sram.inst[i], sram.address[i], sram.byte_length[i]}, 0);
                rst_n = 1'b1;
                return;
            end
            if (v.pat == 1 && k == 130) check("pipe_count_before", fg_count, 0);
            if (v.pat == 1 && k == 131) check("pipe_count_after", fg_count, 1);
            sram.io_valid = v.glitch ? 4'hF : 4'h0;
            sram.io_valid[v.sel] = 1'b1;
            sram.mem_out = v.glitch ? 4'hF : 4'h0;
            sram.mem_out[v.sel] = mask_bit(v.pat, k);
            sram.rw_done = '0;
            if (v.same_cycle && k == v.nbits - 1) sram.rw_done[v.sel] = 1'b1;
            execute = v.reexec && (k == 50);
            if (v.reexec && k == 50) sram_select_in = v.sel ^ 2'd1;
            @(negedge clk);
        end
        idle_inputs();
        if (!v.same_cycle) begin
            sram.rw_done[v.sel] = 1'b1;
            @(negedge clk);
            sram.rw_done = '0;
        end
        check("job_done_pulse", job_done, 1);
        check("finish_state", dbg_state, S_FINISH);
        repeat (3) @(negedge clk);
        check("job_done_count", jd_count, 1);
        check("read_cycles", read_cycles, 1);
        check("idle_state", dbg_state, S_IDLE);
        check("idle_ports", {sram.address[v.sel], sram.byte_length[v.sel]}, 0);
        check("fg_count", fg_count, v.e_count);
        check("bbox_valid", bbox_valid, v.e_valid);
        check("short_read", short_read, v.e_short);
        check("min_x", min_x, v.e_minx);
        check("max_x", max_x, v.e_maxx);
        check("min_y", min_y, v.e_miny);
        check("max_y", max_y, v.e_maxy);
`ifdef MASK_STATISTICS_CENTROID_EN
        check("sum_x", sum_x, v.e_sumx);
        check("sum_y", sum_y, v.e_sumy);
`endif
    endtask

    // ---------------- test sequence ----------------
    initial begin
        //          pat sel nbits  same gap glt re  count minx maxx miny maxy vld sht sumx     sumy
        vecs[0] = '{0, 2'd2, 16384, 1, 0, 0, 0,   0,    0,   0,   0,   0,  0,  0, 0,       0};
        vecs[1] = '{1, 2'd0, 16384, 0, 0, 0, 1,   1,    2,   2,   1,   1,  1,  0, 2,       1};
        vecs[2] = '{2, 2'd1, 16384, 1, 0, 0, 0,   55,   10,  20,  5,   9,  1,  0, 825,     385};
        vecs[3] = '{2, 2'd0, 1000,  0, 1, 1, 0,   33,   10,  20,  5,   7,  1,  1, 495,     198};
        vecs[4] = '{3, 2'd1, 1000,  1, 0, 1, 0,   1000, 0,   127, 0,   7,  1,  1, 62252,   3416};
        vecs[5] = '{3, 2'd3, 16389, 1, 0, 0, 0,   16384, 0,  127, 0,   127, 1, 0, 1040384, 1040384};

        sram_select_in = '0;
        inst_address = '0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", dbg_state, S_IDLE);
        check("reset_outputs", {job_done, fg_count, bbox_valid, short_read}, 0);
        check("reset_bbox", {min_x, max_x, min_y, max_y}, 0);
        for (int i = 0; i < 4; i++)
            check("reset_port", {sram.inst[i], sram.address[i], sram.byte_length[i]}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_job(vecs[i], -1);

        run_job(vecs[2], 700);
        run_job(vecs[5], -1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
